// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage
// ----------------------------------------------------------------------------
// Purpose
//   This is the M->W pipeline register of the five-stage MIPS-style core,
//   followed by the writeback data selector that drives the GRF write port.
//   The same outputs are also the W-stage forwarding source for the hazard
//   unit.
//
// Configuration
//   WB_LOAD_EXT_EN : when defined, W_RegWD also decodes lb/lbu/lh/lhu.
//                    The byte or halfword is extracted from the registered
//                    DM read data. Registered ALUout[1:0] (little-endian)
//                    picks the byte, and ALUout[1] picks the halfword.
//                    When the macro is undefined, those opcodes fall to the
//                    ALUout default.
//
// Parameters
//   PC_RESET       : value loaded into W_PC while reset is asserted.
//
// Ports
//   clk            in   1   sole clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   en             in   1   pipeline-register load enable (0 holds state)
//   flush          in   1   load a bubble instead of M-stage data
//   in_PC          in  32   M-stage PC
//   in_instruction in  32   M-stage instruction
//   in_ALUout      in  32   M-stage ALU result
//   in_Shift       in  32   M-stage shifter / lui result
//   in_DMout       in  32   M-stage data-memory read data
//   in_RegWreg     in   5   M-stage destination register
//   in_RegWrite    in   1   M-stage register write enable
//   in_Tnew        in   2   M-stage Tnew
//   W_PC           out 32   registered PC
//   W_instruction  out 32   registered instruction
//   W_RegWreg      out  5   GRF write address
//   W_RegWD        out 32   GRF write data
//   W_RegWrite     out  1   GRF write enable (never set for $0 or a bubble)
//   W_Tnew         out  2   W-stage Tnew for the hazard unit
//   W_valid        out  1   stage holds a real instruction
// ============================================================================
module writeback_stage #(
  parameter logic [31:0] PC_RESET = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_ALUout,
  input  logic [31:0] in_Shift,
  input  logic [31:0] in_DMout,
  input  logic [4:0]  in_RegWreg,
  input  logic        in_RegWrite,
  input  logic [1:0]  in_Tnew,
  output logic [31:0] W_PC,
  output logic [31:0] W_instruction,
  output logic [4:0]  W_RegWreg,
  output logic [31:0] W_RegWD,
  output logic        W_RegWrite,
  output logic [1:0]  W_Tnew,
  output logic        W_valid
);

  // Opcodes (instruction bits [31:26]) that choose a non-ALU writeback source.
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
`ifdef WB_LOAD_EXT_EN
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
`endif

  // --------------------------------------------------------------------------
  // W pipeline register contents
  // --------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] alu_q;
  logic [31:0] shift_q;
  logic [31:0] dm_q;
  logic [4:0]  regwreg_q;
  logic        regwrite_q;
  logic [1:0]  tnew_q;
  logic        valid_q;

  // Tnew counts the cycles until a result is ready. One stage has elapsed by
  // the time the instruction reaches W, so the count drops by one. A result
  // that was already ready stays at zero rather than wrapping to 3.
  logic [1:0] tnew_dec;

  always_comb begin
    tnew_dec = 2'd0;
    if (in_Tnew != 2'd0) begin
      tnew_dec = in_Tnew - 2'd1;
    end
  end

  // Priority is reset, then flush, then en.
  // A flush loads a bubble even when en is low, so a stalled stage can still
  // be squashed. The bubble keeps the old PC, which leaves the exception and
  // debug views of the PC intact. The stored data words are left alone
  // because nothing reads them once the slot is invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      instr_q    <= 32'd0;
      alu_q      <= 32'd0;
      shift_q    <= 32'd0;
      dm_q       <= 32'd0;
      regwreg_q  <= 5'd0;
      regwrite_q <= 1'b0;
      tnew_q     <= 2'd0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      instr_q    <= 32'd0;
      regwreg_q  <= 5'd0;
      regwrite_q <= 1'b0;
      tnew_q     <= 2'd0;
      valid_q    <= 1'b0;
    end else if (en) begin
      pc_q       <= in_PC;
      instr_q    <= in_instruction;
      alu_q      <= in_ALUout;
      shift_q    <= in_Shift;
      dm_q       <= in_DMout;
      regwreg_q  <= in_RegWreg;
      regwrite_q <= in_RegWrite;
      tnew_q     <= tnew_dec;
      valid_q    <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Writeback data selection
  // --------------------------------------------------------------------------
  logic [5:0]  opcode;
  logic [31:0] link_addr;

  assign opcode    = instr_q[31:26];
  // jal links to the instruction after its delay slot.
  assign link_addr = pc_q + 32'd8;

`ifdef WB_LOAD_EXT_EN
  // Memory is little-endian. The low address bits that the ALU computed pick
  // the byte lane, and address bit 1 picks the upper or lower halfword.
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = dm_q[7:0];
    case (alu_q[1:0])
      2'b00:   load_byte = dm_q[7:0];
      2'b01:   load_byte = dm_q[15:8];
      2'b10:   load_byte = dm_q[23:16];
      default: load_byte = dm_q[31:24];
    endcase
    load_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
  end
`endif

  // Any opcode that is not listed writes back the ALU result.
  always_comb begin
    W_RegWD = alu_q;
    case (opcode)
      OP_LW:   W_RegWD = dm_q;
      OP_LUI:  W_RegWD = shift_q;
      OP_JAL:  W_RegWD = link_addr;
`ifdef WB_LOAD_EXT_EN
      OP_LB:   W_RegWD = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  W_RegWD = {24'd0, load_byte};
      OP_LH:   W_RegWD = {{16{load_half[15]}}, load_half};
      OP_LHU:  W_RegWD = {16'd0, load_half};
`endif
      default: W_RegWD = alu_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The write enable is qualified at the output rather than at capture time.
  // This way a bubble or a write to $0 can never reach the GRF or the
  // forwarding muxes, whatever the M stage sent.
  assign W_RegWrite    = regwrite_q & valid_q & (regwreg_q != 5'd0);
  assign W_PC          = pc_q;
  assign W_instruction = instr_q;
  assign W_RegWreg     = regwreg_q;
  assign W_Tnew        = tnew_q;
  assign W_valid       = valid_q;

endmodule

// File: tb/tb_writeback_stage.sv
// ============================================================================
// tb_writeback_stage
// ----------------------------------------------------------------------------
// Directed stimulus for writeback_stage, with hand-computed literal
// expectations. A behavioural model of the W register is checked against
// the DUT every cycle.
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] in_PC, in_instruction, in_ALUout, in_Shift, in_DMout;
  logic [4:0]  in_RegWreg;
  logic        in_RegWrite;
  logic [1:0]  in_Tnew;
  logic [31:0] W_PC, W_instruction, W_RegWD;
  logic [4:0]  W_RegWreg;
  logic        W_RegWrite, W_valid;
  logic [1:0]  W_Tnew;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.PC_RESET(32'h00003000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_PC(in_PC), .in_instruction(in_instruction), .in_ALUout(in_ALUout),
    .in_Shift(in_Shift), .in_DMout(in_DMout), .in_RegWreg(in_RegWreg),
    .in_RegWrite(in_RegWrite), .in_Tnew(in_Tnew),
    .W_PC(W_PC), .W_instruction(W_instruction), .W_RegWreg(W_RegWreg),
    .W_RegWD(W_RegWD), .W_RegWrite(W_RegWrite), .W_Tnew(W_Tnew),
    .W_valid(W_valid)
  );

  always #5 clk = ~clk;

  // Each comparison is counted, and a mismatch prints one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: the architectural contents of the W slot
  // --------------------------------------------------------------------------
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_alu, m_shift, m_dm;
  logic [4:0]  m_reg;
  logic        m_we, m_valid;
  int          m_tnew;

  function automatic logic [31:0] modelRegWd();
    logic [31:0] b, h;
    b = m_dm >> (8 * m_alu[1:0]);
    h = m_dm >> (16 * m_alu[1]);
    case (m_instr[31:26])
      6'b100011: return m_dm;
      6'b001111: return m_shift;
      6'b000011: return m_pc + 32'd8;
`ifdef WB_LOAD_EXT_EN
      6'b100000: return {{24{b[7]}}, b[7:0]};
      6'b100100: return {24'd0, b[7:0]};
      6'b100001: return {{16{h[15]}}, h[15:0]};
      6'b100101: return {16'd0, h[15:0]};
`endif
      default:   return m_alu;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1'b1;
      m_pc = 32'h00003000; m_instr = 0; m_alu = 0; m_shift = 0; m_dm = 0;
      m_reg = 0; m_we = 0; m_tnew = 0; m_valid = 0;
    end else if (flush) begin
      m_instr = 0; m_reg = 0; m_we = 0; m_tnew = 0; m_valid = 0;
    end else if (en) begin
      m_pc = in_PC; m_instr = in_instruction; m_alu = in_ALUout;
      m_shift = in_Shift; m_dm = in_DMout; m_reg = in_RegWreg;
      m_we = in_RegWrite; m_valid = 1;
      m_tnew = (in_Tnew > 0) ? int'(in_Tnew) - 1 : 0;
    end
  end

  // The model is compared against the DUT on every falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("model W_PC", W_PC, m_pc);
      checkOutput("model W_instruction", W_instruction, m_instr);
      checkOutput("model W_RegWreg", {27'd0, W_RegWreg}, {27'd0, m_reg});
      checkOutput("model W_RegWrite", {31'd0, W_RegWrite},
                  {31'd0, m_we && m_valid && (m_reg != 0)});
      checkOutput("model W_Tnew", {30'd0, W_Tnew}, m_tnew);
      checkOutput("model W_valid", {31'd0, W_valid}, {31'd0, m_valid});
      if (m_valid) checkOutput("model W_RegWD", W_RegWD, modelRegWd());
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] mkInstr(input logic [5:0] op);
    return {op, 5'd3, 5'd8, 16'h0040};
  endfunction

  task automatic setInputs(input logic [31:0] pc, input logic [5:0] op,
                           input logic [31:0] alu, input logic [31:0] sh,
                           input logic [31:0] dm, input logic [4:0] rd,
                           input logic we, input logic [1:0] tn);
    in_PC = pc; in_instruction = mkInstr(op); in_ALUout = alu;
    in_Shift = sh; in_DMout = dm; in_RegWreg = rd; in_RegWrite = we;
    in_Tnew = tn;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic f);
    reset = r; en = e; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    setInputs(32'h11111110, 6'b100011, 32'h5, 32'h6, 32'h7, 5'd9, 1'b1, 2'd2);

    // Two reset cycles with en active, then idle
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("reset W_PC", W_PC, 32'h00003000);
    checkOutput("reset W_RegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("reset W_valid", {31'd0, W_valid}, 32'd0);
    checkOutput("reset W_Tnew", {30'd0, W_Tnew}, 32'd0);
    checkOutput("reset W_RegWD", W_RegWD, 32'd0);
    checkOutput("reset W_instruction", W_instruction, 32'd0);

    // jal followed directly by lw
    setInputs(32'h00003010, 6'b000011, 32'h0, 32'h0, 32'h0, 5'd31, 1'b1, 2'd0);
    applyStimulus(0, 1, 0);
    checkOutput("jal W_RegWD", W_RegWD, 32'h00003018);
    checkOutput("jal W_valid", {31'd0, W_valid}, 32'd1);
    checkOutput("jal W_RegWrite", {31'd0, W_RegWrite}, 32'd1);
    setInputs(32'h00003014, 6'b100011, 32'h100, 32'h0, 32'hDEADBEEF, 5'd8, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
    checkOutput("lw W_RegWD", W_RegWD, 32'hDEADBEEF);
    checkOutput("lw W_Tnew", {30'd0, W_Tnew}, 32'd0);
    checkOutput("lw W_RegWrite", {31'd0, W_RegWrite}, 32'd1);
    checkOutput("lw W_PC", W_PC, 32'h00003014);

    // An addu to $0 must not write
    setInputs(32'h00003018, 6'b000000, 32'h55, 32'h0, 32'h0, 5'd0, 1'b1, 2'd2);
    applyStimulus(0, 1, 0);
    checkOutput("addu $0 W_RegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("addu Tnew 2->1", {30'd0, W_Tnew}, 32'd1);
    checkOutput("addu W_RegWD", W_RegWD, 32'h55);

    // lui, held for three cycles, then flushed
    setInputs(32'h00003020, 6'b001111, 32'hAAAA, 32'h12340000, 32'h0, 5'd5, 1'b1, 2'd3);
    applyStimulus(0, 1, 0);
    checkOutput("lui Tnew 3->2", {30'd0, W_Tnew}, 32'd2);
    setInputs(32'h00009999, 6'b100011, 32'h1, 32'h2, 32'h3, 5'd7, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("lui hold W_RegWD", W_RegWD, 32'h12340000);
      checkOutput("lui hold W_RegWrite", {31'd0, W_RegWrite}, 32'd1);
      checkOutput("lui hold W_PC", W_PC, 32'h00003020);
    end
    applyStimulus(0, 1, 1);
    checkOutput("flush W_valid", {31'd0, W_valid}, 32'd0);
    checkOutput("flush W_RegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("flush W_PC kept", W_PC, 32'h00003020);
    checkOutput("flush W_instruction", W_instruction, 32'd0);

    // Flush with en low still squashes the slot
    setInputs(32'h00003024, 6'b000000, 32'h77, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    checkOutput("flush en=0 W_valid", {31'd0, W_valid}, 32'd0);
    checkOutput("flush en=0 W_RegWrite", {31'd0, W_RegWrite}, 32'd0);

    // Reset discards a held instruction
    setInputs(32'h00003028, 6'b100011, 32'h0, 32'h0, 32'h1234, 5'd6, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("reset discard W_RegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("reset discard W_PC", W_PC, 32'h00003000);

    // Sub-word loads
    setInputs(32'h00003030, 6'b100000, 32'h00001003, 32'h0, 32'h80FF7F01, 5'd9, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
`ifdef WB_LOAD_EXT_EN
    checkOutput("lb W_RegWD", W_RegWD, 32'hFFFFFF80);
`else
    checkOutput("lb W_RegWD", W_RegWD, 32'h00001003);
`endif
    setInputs(32'h00003034, 6'b100101, 32'h00000002, 32'h0, 32'h80FF7F01, 5'd9, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
`ifdef WB_LOAD_EXT_EN
    checkOutput("lhu W_RegWD", W_RegWD, 32'h000080FF);
`else
    checkOutput("lhu W_RegWD", W_RegWD, 32'h00000002);
`endif
    setInputs(32'h00003038, 6'b100100, 32'h00000001, 32'h0, 32'h80FF7F01, 5'd9, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);
    setInputs(32'h0000303C, 6'b100001, 32'h00000000, 32'h0, 32'h80FF8F01, 5'd9, 1'b1, 2'd1);
    applyStimulus(0, 1, 0);

    // The jal link address wraps modulo 2^32
    setInputs(32'hFFFFFFFC, 6'b000011, 32'h0, 32'h0, 32'h0, 5'd31, 1'b1, 2'd0);
    applyStimulus(0, 1, 0);
    checkOutput("jal wrap W_RegWD", W_RegWD, 32'h00000004);

    // Mixed traffic, checked only against the model
    for (int i = 0; i < 40; i++) begin
      logic [5:0] ops [8];
      ops = '{6'b100011, 6'b001111, 6'b000011, 6'b000000,
              6'b100000, 6'b100100, 6'b100001, 6'b100101};
      setInputs($urandom, ops[$urandom_range(0, 7)], $urandom, $urandom,
                $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                2'($urandom_range(0, 3)));
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0));
    end

    applyStimulus(0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have parameter PC_RESET, default 32'h00003000, the W_PC value held in reset.
REQ-002 The module SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  pipeline-register load enable; 0 holds all state.
REQ-005 flush  in  1  load a bubble instead of M-stage data.
REQ-006 in_PC, in_instruction, in_ALUout, in_Shift, in_DMout  in  32 each  M-stage PC, instruction, ALU result, shifter/lui result, DM read data.
REQ-007 in_RegWreg  in  5  M-stage destination register; in_RegWrite  in  1  M-stage write enable; in_Tnew  in  2  M-stage Tnew.
REQ-008 W_PC, W_instruction  out  32 each  registered PC and instruction.
REQ-009 W_RegWreg  out  5; W_RegWD  out  32; W_RegWrite  out  1  GRF write port and W-stage forwarding source.
REQ-010 W_Tnew  out  2  W-stage Tnew for hazard unit; W_valid  out  1  stage holds a real instruction.

Function
REQ-011 On a rising clk with reset=0, flush=0 and en=1, all in_* SHALL be captured into the W register and W_valid SHALL become 1, giving 1-cycle latency from M to W.
REQ-012 With flush=1 and en=1, the register SHALL load a bubble: instruction 0, RegWrite 0, RegWreg 0, Tnew 0, W_valid 0, PC unchanged.
REQ-013 With flush=1 and en=0, flush SHALL take priority and the register SHALL load a bubble.
REQ-014 With en=0 and flush=0, every output SHALL hold its previous value.
REQ-015 The captured Tnew SHALL be in_Tnew-1, saturating at 0. in_Tnew=0 SHALL capture 0.
REQ-016 W_RegWD SHALL be combinational from the W register, selected by opcode bits [31:26]: 100011 (lw) gives DMout; 001111 (lui) gives Shift; 000011 (jal) gives PC+8 mod 2^32; otherwise ALUout.
REQ-017 W_RegWrite SHALL be 0 whenever the registered RegWreg is 0, so $0 is never written or forwarded.
REQ-018 W_RegWrite SHALL be 0 whenever W_valid is 0.
REQ-019 Back-to-back captures on consecutive cycles SHALL each be visible for exactly one cycle, with no bubble inserted.

Reset
REQ-020 While reset=1 at a clk edge, the module SHALL load: W_PC=PC_RESET, W_instruction=0, W_RegWreg=0, W_RegWrite=0, W_Tnew=0, W_valid=0, and stored ALUout/Shift/DMout=0.
REQ-021 Reset SHALL override en and flush.
REQ-022 A reset asserted while an instruction is held SHALL discard it, so no GRF write occurs in the following cycle.

Configuration
REQ-023 The macro WB_LOAD_EXT_EN SHALL control sub-word load extraction.
REQ-024 With WB_LOAD_EXT_EN defined, W_RegWD SHALL also decode the following opcodes, with the byte/halfword chosen by registered ALUout[1:0] (little-endian) and halfword select by ALUout[1]:
- 100000 (lb): sign-extended byte.
- 100100 (lbu): zero-extended byte.
- 100001 (lh): sign-extended halfword.
- 100101 (lhu): zero-extended halfword.
REQ-025 With WB_LOAD_EXT_EN undefined, those opcodes SHALL fall to the ALUout default.

Verification
REQ-026 Reset for 2 cycles, then idle -> W_PC=32'h00003000, W_RegWrite=0, W_valid=0, W_Tnew=0.
REQ-027 Capture jal at in_PC=32'h00003010 with RegWreg=31, and next cycle capture lw with RegWreg=8, DMout=32'hDEADBEEF, Tnew=1 -> cycle 1: W_RegWD=32'h00003018; cycle 2: W_RegWD=32'hDEADBEEF, W_Tnew=0, W_RegWrite=1.
REQ-028 Capture addu with RegWreg=0, RegWrite=1 -> W_RegWrite=0.
REQ-029 Hold en=0 for 3 cycles after capturing lui with Shift=32'h12340000, then assert flush=1 -> lui outputs stay stable for 3 cycles, then W_valid=0 and W_RegWrite=0.
REQ-030 With WB_LOAD_EXT_EN defined, capture lb with DMout=32'h80FF7F01 and ALUout[1:0]=2'b11 -> W_RegWD=32'hFFFFFF80; lhu with ALUout[1]=1 -> W_RegWD=32'h000080FF. With WB_LOAD_EXT_EN undefined, the same lb -> W_RegWD equals ALUout.
